seq_input_checker: RTL

SEQ_INPUT_CHECKER -- requirements
Module: seq_input_checker

---
 rtl/seq_input_checker_pkg.sv | 43 ++++
 rtl/seq_input_checker_btn_debounce.sv | 41 ++++
 rtl/seq_input_checker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/seq_input_checker_pkg.sv
// rtl/seq_input_checker_pkg.sv - shared levels, step counts, slot geometry and FSM states
package seq_input_checker_pkg;

   localparam logic [2:0] LV1 = 3'b001;
   localparam logic [2:0] LV2 = 3'b010;
   localparam logic [2:0] LV3 = 3'b100;

   localparam logic [4:0] STEPS_LV1 = 5'd8;
   localparam logic [4:0] STEPS_LV2 = 5'd12;
   localparam logic [4:0] STEPS_LV3 = 5'd16;

   localparam int SLOT_W    = 3;
   localparam int MAX_SLOTS = 16;
   localparam int PATTERN_W = SLOT_W * MAX_SLOTS;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PRESS,
      ECHO,
      WAIT_RELEASE,
      DONE
   } state_t;

   // Zero marks a level that is not one of the three one-hot encodings.
   function automatic logic [4:0] steps_for_level(input logic [2:0] lv);
      case (lv)
         LV1:     return STEPS_LV1;
         LV2:     return STEPS_LV2;
         LV3:     return STEPS_LV3;
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [2:0] onehot_index(input logic [7:0] v);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seq_input_checker_btn_debounce.sv
// rtl/seq_input_checker_btn_debounce.sv - per-bit 2-flop synchroniser plus stable-sample debounce
module btn_debounce #(
   parameter int W          = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic         clk_1,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [W-1:0]  meta;
   logic [W-1:0]  sync;
   logic [CW-1:0] cnt [W];

   // A bit flips only after DEB_CYCLES consecutive synchronised samples disagree with it.
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         meta   <= '0;
         sync   <= '0;
         stable <= '0;
         for (int i = 0; i < W; i++) cnt[i] <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         for (int i = 0; i < W; i++) begin
            if (sync[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
               stable[i] <= sync[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seq_input_checker.sv
// rtl/seq_input_checker.sv - button sequence checker: latch pattern, score presses, report win
module seq_input_checker
   import seq_input_checker_pkg::*;
#(
   parameter int DEB_CYCLES     = 4,
   parameter int ECHO_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                 clk_1,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           level,
   input  logic [PATTERN_W-1:0] pattern_flat,
   input  logic [7:0]           btn,
   output logic                 busy,
   output logic [7:0]           echo_led,
   output logic [4:0]           step_idx,
   output logic [4:0]           correct_cnt,
   output logic                 done,
   output logic                 win
);

   localparam int EW = $clog2(ECHO_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   state_t               state;
   logic [PATTERN_W-1:0] pattern_q;
   logic [4:0]           step_cnt;
   logic [EW-1:0]        echo_cnt;
   logic [TW-1:0]        tmo_cnt;
   logic [7:0]           db;
   logic [7:0]           db_prev;
   logic [4:0]           start_steps;
   logic [2:0]           press_idx;
   logic [2:0]           slot_val;
   logic                 rise_any;
   logic                 single;
   logic                 match;

   btn_debounce #(
      .W          (8),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk_1  (clk_1),
      .rst    (rst),
      .raw    (btn),
      .stable (db)
   );

   assign start_steps = steps_for_level(level);
   assign rise_any    = |(db & ~db_prev);
   assign single      = (db != 8'd0) && ((db & (db - 8'd1)) == 8'd0);
   assign press_idx   = onehot_index(db);
   assign slot_val    = pattern_q[step_idx[3:0] * SLOT_W +: SLOT_W];
   assign match       = single && (press_idx == slot_val);

   // Edge detection runs in every state, so a button held across start never shows a rise.
   always_ff @(posedge clk_1 or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         pattern_q   <= '0;
         step_cnt    <= '0;
         echo_cnt    <= '0;
         tmo_cnt     <= '0;
         db_prev     <= '0;
         busy        <= 1'b0;
         echo_led    <= '0;
         step_idx    <= '0;
         correct_cnt <= '0;
         done        <= 1'b0;
         win         <= 1'b0;
      end else begin
         db_prev <= db;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (start_steps != 5'd0)) begin
                  pattern_q   <= pattern_flat;
                  step_cnt    <= start_steps;
                  step_idx    <= '0;
                  correct_cnt <= '0;
                  win         <= 1'b0;
                  busy        <= 1'b1;
                  tmo_cnt     <= '0;
                  state       <= WAIT_PRESS;
               end
            end
            WAIT_PRESS: begin
               if (rise_any) begin
                  step_idx <= step_idx + 5'd1;
                  if (match) correct_cnt <= correct_cnt + 5'd1;
                  echo_led <= single ? (8'b1 << press_idx) : 8'hFF;
                  echo_cnt <= '0;
                  state    <= ECHO;
               end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  step_idx <= step_cnt;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  win      <= (correct_cnt == step_cnt);
                  state    <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ECHO: begin
               if (echo_cnt == EW'(ECHO_CYCLES - 1)) begin
                  echo_led <= '0;
                  state    <= WAIT_RELEASE;
               end else begin
                  echo_cnt <= echo_cnt + 1'b1;
               end
            end
            WAIT_RELEASE: begin
               if (db == 8'd0) begin
                  if (step_idx == step_cnt) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     win   <= (correct_cnt == step_cnt);
                     state <= DONE;
                  end else begin
                     tmo_cnt <= '0;
                     state   <= WAIT_PRESS;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
